// File: rtl/load_ins_pkg.sv
// Shared definitions for the LOAD instruction front end: header code, field
// positions inside the 96-bit word, dispatch states and the queued command.
package load_ins_pkg;

    localparam logic [3:0] HEAD_LOAD = 4'b0001;

    localparam int HDR_HI   = 31;
    localparam int HDR_LO   = 28;
    localparam int DDR_HI   = 95;
    localparam int DDR_LO   = 64;
    localparam int IWB_HI   = 63;
    localparam int IWB_LO   = 62;
    localparam int LINE_HI  = 61;
    localparam int LINE_LO  = 50;
    localparam int TOTAL_HI = 49;
    localparam int TOTAL_LO = 34;
    localparam int ZF_BIT   = 33;
    localparam int BID_HI   = 19;
    localparam int BID_LO   = 12;
    localparam int BADDR_HI = 11;
    localparam int BADDR_LO = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } disp_state_e;

    typedef struct packed {
        logic [31:0] ddr_addr;
        logic [1:0]  iwb_id;
        logic [11:0] line_size;
        logic [15:0] total_size;
        logic        zero_fill;
        logic [7:0]  bank_id;
        logic [11:0] bank_addr;
    } ld_cmd_t;

    localparam int CMD_W = $bits(ld_cmd_t);

endpackage

// File: rtl/ld_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers wrap
// naturally. A push into a full FIFO is accepted only alongside a pop.
module ld_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 wr_data,
    input  logic                         pop,
    output logic [W-1:0]                 rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/load_ins_queue_parser.sv
// LOAD instruction front end: queues decoded LOAD words, dispatches them one
// at a time to the DDR engine and returns completions through a done/ack pair.
//
// state | meaning
// IDLE  | no command executing; pops the queue head when one is waiting
// BUSY  | a dispatched command is running; waits for wr_done
module load_ins_queue_parser
    import load_ins_pkg::*;
#(
    parameter int IWB_SEL_W   = 2,
    parameter int BID_W       = 8,
    parameter int MAX_ADDR_W  = 12,
    parameter int DDR_ADDR_W  = 32,
    parameter int LINE_SIZE_W = 12,
    parameter int ALL_SIZE_W  = 16,
    parameter int INS_LEN     = 96,
    parameter int CMD_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INS_LEN-1:0]             ins_data,
    input  logic                           ins_valid,
    output logic                           ins_ready,
    output logic                           ins_err,
    output logic                           ins_done,
    input  logic                           ins_done_ack,
    input  logic                           wr_done,
    output logic                           start,
    output logic                           busy,
    output logic [$clog2(CMD_DEPTH+1)-1:0] outstanding,
    output logic [IWB_SEL_W-1:0]           reg_rd_iwb_id,
    output logic [BID_W-1:0]               reg_rd_bank_id,
    output logic [MAX_ADDR_W-1:0]          reg_rd_bank_addr,
    output logic [LINE_SIZE_W-1:0]         reg_rd_line_size,
    output logic [ALL_SIZE_W-1:0]          reg_rd_total_size,
    output logic                           reg_zero_fill,
    output logic [DDR_ADDR_W-1:0]          reg_rd_ddr_addr
);

    localparam int OUT_W = $clog2(CMD_DEPTH+1);

    disp_state_e       state_q, state_d;
    ld_cmd_t           cmd_in;
    ld_cmd_t           cmd_head;
    ld_cmd_t           cmd_q;
    logic              accept;
    logic              is_load;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OUT_W-1:0]  fifo_count;
    logic [OUT_W-1:0]  done_pending_q, done_pending_d;
    logic              done_inc;
    logic              done_dec;
    logic              start_q;
    logic              ins_err_q;
    logic              ins_done_q;
    logic              unused_bits;

    // Reserved instruction bits carry no meaning for a LOAD.
    assign unused_bits = ^{ins_data[32], ins_data[27:20]};

    assign is_load   = (ins_data[HDR_HI:HDR_LO] == HEAD_LOAD);
    assign accept    = ins_valid && ins_ready;
    assign fifo_push = accept && is_load && !fifo_full;

    always_comb begin
        cmd_in            = '0;
        cmd_in.ddr_addr   = ins_data[DDR_HI:DDR_LO];
        cmd_in.iwb_id     = ins_data[IWB_HI:IWB_LO];
        cmd_in.line_size  = ins_data[LINE_HI:LINE_LO];
        cmd_in.total_size = ins_data[TOTAL_HI:TOTAL_LO];
        cmd_in.zero_fill  = ins_data[ZF_BIT];
        cmd_in.bank_id    = ins_data[BID_HI:BID_LO];
        cmd_in.bank_addr  = ins_data[BADDR_HI:BADDR_LO];
    end

    ld_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (cmd_in),
        .pop     (fifo_pop),
        .rd_data (cmd_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q == ST_BUSY);
    assign done_inc = busy && wr_done;
    assign done_dec = ins_done_q && ins_done_ack;

    always_comb begin
        done_pending_d = done_pending_q;
        case ({done_inc, done_dec})
            2'b10:   done_pending_d = done_pending_q + OUT_W'(1);
            2'b01:   done_pending_d = done_pending_q - OUT_W'(1);
            default: done_pending_d = done_pending_q;
        endcase
    end

    // Every term is a register, so ins_ready has no path from ins_valid.
    assign outstanding = fifo_count + {{(OUT_W-1){1'b0}}, busy} + done_pending_q;
    assign ins_ready   = (outstanding < OUT_W'(CMD_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            start_q        <= 1'b0;
            ins_err_q      <= 1'b0;
            ins_done_q     <= 1'b0;
            done_pending_q <= '0;
        end else begin
            state_q        <= state_d;
            start_q        <= fifo_pop;
            ins_err_q      <= accept && !is_load;
            ins_done_q     <= (done_pending_d != '0);
            done_pending_q <= done_pending_d;
            if (fifo_pop) begin
                cmd_q <= cmd_head;
            end
        end
    end

    assign start             = start_q;
    assign ins_err           = ins_err_q;
    assign ins_done          = ins_done_q;
    assign reg_rd_ddr_addr   = cmd_q.ddr_addr;
    assign reg_rd_iwb_id     = cmd_q.iwb_id;
    assign reg_rd_line_size  = cmd_q.line_size;
    assign reg_rd_total_size = cmd_q.total_size;
    assign reg_zero_fill     = cmd_q.zero_fill;
    assign reg_rd_bank_id    = cmd_q.bank_id;
    assign reg_rd_bank_addr  = cmd_q.bank_addr;

endmodule

// File: tb/tb_load_ins_queue_parser.sv
// Directed bench for load_ins_queue_parser: hand-built instruction words,
// expected counts/flags written out per step, start pulses scoreboarded in order.
module tb_load_ins_queue_parser;

    typedef struct packed {
        logic [31:0] ddr;
        logic [1:0]  iwb;
        logic [11:0] line;
        logic [15:0] tot;
        logic        zf;
        logic [7:0]  bid;
        logic [11:0] ba;
    } fld_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] ins_data;
    logic        ins_valid;
    logic        ins_ready;
    logic        ins_err;
    logic        ins_done;
    logic        ins_done_ack;
    logic        wr_done;
    logic        start;
    logic        busy;
    logic [2:0]  outstanding;
    logic [1:0]  reg_rd_iwb_id;
    logic [7:0]  reg_rd_bank_id;
    logic [11:0] reg_rd_bank_addr;
    logic [11:0] reg_rd_line_size;
    logic [15:0] reg_rd_total_size;
    logic        reg_zero_fill;
    logic [31:0] reg_rd_ddr_addr;

    int n_chk  = 0;
    int n_fail = 0;

    fld_t cap_q[$];
    fld_t exp_q[$];

    always #5 clk = ~clk;

    load_ins_queue_parser dut (
        .clk               (clk),
        .rst               (rst),
        .ins_data          (ins_data),
        .ins_valid         (ins_valid),
        .ins_ready         (ins_ready),
        .ins_err           (ins_err),
        .ins_done          (ins_done),
        .ins_done_ack      (ins_done_ack),
        .wr_done           (wr_done),
        .start             (start),
        .busy              (busy),
        .outstanding       (outstanding),
        .reg_rd_iwb_id     (reg_rd_iwb_id),
        .reg_rd_bank_id    (reg_rd_bank_id),
        .reg_rd_bank_addr  (reg_rd_bank_addr),
        .reg_rd_line_size  (reg_rd_line_size),
        .reg_rd_total_size (reg_rd_total_size),
        .reg_zero_fill     (reg_zero_fill),
        .reg_rd_ddr_addr   (reg_rd_ddr_addr)
    );

    always @(negedge clk) begin
        if (start) begin
            cap_q.push_back({reg_rd_ddr_addr, reg_rd_iwb_id, reg_rd_line_size,
                             reg_rd_total_size, reg_zero_fill, reg_rd_bank_id,
                             reg_rd_bank_addr});
        end
    end

    task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] mk_ins(input fld_t f, input logic [3:0] hdr);
        return {f.ddr, f.iwb, f.line, f.tot, f.zf, 1'b0, hdr, 8'h00, f.bid, f.ba};
    endfunction

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        check_val(tag, busy, 1'b1);
    endtask

    fld_t l1, b0, b1, b2, b3, b5, r0, r1, r2;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        l1 = '{32'h1000_0040, 2'd2, 12'h040, 16'h0200, 1'b1, 8'h05, 12'h123};
        b0 = '{32'h2000_0000, 2'd1, 12'h001, 16'h0010, 1'b0, 8'h11, 12'h001};
        b1 = '{32'h2000_0100, 2'd3, 12'hfff, 16'hffff, 1'b1, 8'hff, 12'hfff};
        b2 = '{32'h0000_0000, 2'd0, 12'h000, 16'h0000, 1'b0, 8'h00, 12'h000};
        b3 = '{32'hdead_beef, 2'd2, 12'habc, 16'h1234, 1'b1, 8'ha5, 12'h5a5};
        b5 = '{32'hcafe_f00d, 2'd1, 12'h7ff, 16'h8000, 1'b0, 8'h3c, 12'h800};
        r0 = '{32'h1234_5678, 2'd3, 12'h100, 16'h0001, 1'b1, 8'h7e, 12'h0ff};
        r1 = '{32'h8765_4321, 2'd0, 12'h200, 16'h0002, 1'b0, 8'h01, 12'h00f};
        r2 = '{32'h0f0f_0f0f, 2'd1, 12'h300, 16'h0003, 1'b1, 8'h02, 12'h0f0};

        rst = 1'b1; ins_data = '0; ins_valid = 1'b0; ins_done_ack = 1'b0; wr_done = 1'b0;
        step(); step();
        rst = 1'b0;
        check_val("rst_ready", ins_ready, 1'b1);
        check_val("rst_start", start, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_outstanding", outstanding, 3'd0);
        check_val("rst_done", ins_done, 1'b0);
        check_val("rst_err", ins_err, 1'b0);
        check_val("rst_ddr", reg_rd_ddr_addr, 32'h0);

        // single LOAD: accept at T, start at T+2, wr_done at T+10
        ins_data = mk_ins(l1, 4'b0001); ins_valid = 1'b1;
        check_val("t1_ready", ins_ready, 1'b1);
        exp_q.push_back(l1);
        step(); ins_valid = 1'b0;
        check_val("t1_start_early", start, 1'b0);
        check_val("t1_outst_q", outstanding, 3'd1);
        step();
        check_val("t1_start", start, 1'b1);
        check_val("t1_busy", busy, 1'b1);
        check_val("t1_ddr", reg_rd_ddr_addr, 32'h1000_0040);
        check_val("t1_bid", reg_rd_bank_id, 8'h05);
        check_val("t1_baddr", reg_rd_bank_addr, 12'h123);
        check_val("t1_line", reg_rd_line_size, 12'h040);
        check_val("t1_total", reg_rd_total_size, 16'h0200);
        check_val("t1_zf", reg_zero_fill, 1'b1);
        check_val("t1_iwb", reg_rd_iwb_id, 2'd2);
        step();
        check_val("t1_start_pulse", start, 1'b0);
        repeat (7) step();
        wr_done = 1'b1;
        step(); wr_done = 1'b0;
        check_val("t1_done", ins_done, 1'b1);
        check_val("t1_idle", busy, 1'b0);
        check_val("t1_outst_done", outstanding, 3'd1);
        check_val("t1_ddr_hold", reg_rd_ddr_addr, 32'h1000_0040);
        ins_done_ack = 1'b1;
        step(); ins_done_ack = 1'b0;
        check_val("t1_done_clr", ins_done, 1'b0);
        check_val("t1_outst_clr", outstanding, 3'd0);

        // non-LOAD header
        ins_data = mk_ins(b1, 4'b0010); ins_valid = 1'b1;
        check_val("err_ready", ins_ready, 1'b1);
        step(); ins_valid = 1'b0;
        check_val("err_pulse", ins_err, 1'b1);
        check_val("err_outst", outstanding, 3'd0);
        step();
        check_val("err_pulse_end", ins_err, 1'b0);
        check_val("err_no_start", start, 1'b0);
        check_val("err_no_busy", busy, 1'b0);
        step();
        check_val("err_no_done", ins_done, 1'b0);
        check_val("err_no_start2", start, 1'b0);

        // wr_done while idle with an empty queue
        wr_done = 1'b1;
        step(); wr_done = 1'b0;
        step();
        check_val("idle_wr_done", ins_done, 1'b0);
        check_val("idle_wr_busy", busy, 1'b0);
        check_val("idle_wr_outst", outstanding, 3'd0);

        // four back-to-back LOADs fill the block
        ins_data = mk_ins(b0, 4'b0001); ins_valid = 1'b1; check_val("b2b_rdy0", ins_ready, 1'b1); step();
        ins_data = mk_ins(b1, 4'b0001); check_val("b2b_rdy1", ins_ready, 1'b1); step();
        ins_data = mk_ins(b2, 4'b0001); check_val("b2b_rdy2", ins_ready, 1'b1); step();
        ins_data = mk_ins(b3, 4'b0001); check_val("b2b_rdy3", ins_ready, 1'b1); step();
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
        ins_data = mk_ins(b5, 4'b0001);
        check_val("full_ready", ins_ready, 1'b0);
        check_val("full_outst", outstanding, 3'd4);

        // three completions without ack while the fifth word is held
        wait_busy("wb_b0"); wr_done = 1'b1; step(); wr_done = 1'b0;
        check_val("held_rdy1", ins_ready, 1'b0);
        wait_busy("wb_b1"); wr_done = 1'b1; step(); wr_done = 1'b0;
        wait_busy("wb_b2"); wr_done = 1'b1; step(); wr_done = 1'b0;
        check_val("dp3_done", ins_done, 1'b1);
        check_val("dp3_outst", outstanding, 3'd4);
        check_val("dp3_ready", ins_ready, 1'b0);
        wait_busy("wb_b3");
        check_val("dp3_done_hold", ins_done, 1'b1);
        ins_done_ack = 1'b1;
        step(); ins_done_ack = 1'b0;
        check_val("ack1_outst", outstanding, 3'd3);
        check_val("ack1_ready", ins_ready, 1'b1);
        check_val("ack1_done", ins_done, 1'b1);
        exp_q.push_back(b5);
        step(); ins_valid = 1'b0;
        check_val("b5_accepted", outstanding, 3'd4);

        // wr_done coincident with ack
        wr_done = 1'b1; ins_done_ack = 1'b1;
        step(); wr_done = 1'b0; ins_done_ack = 1'b0;
        check_val("coinc_outst", outstanding, 3'd3);
        check_val("coinc_done", ins_done, 1'b1);
        wait_busy("wb_b5"); wr_done = 1'b1; step(); wr_done = 1'b0;
        check_val("b5_done_outst", outstanding, 3'd3);
        ins_done_ack = 1'b1;
        step();
        check_val("drain1_outst", outstanding, 3'd2);
        check_val("drain1_done", ins_done, 1'b1);
        step();
        check_val("drain2_outst", outstanding, 3'd1);
        check_val("drain2_done", ins_done, 1'b1);
        step();
        check_val("drain3_outst", outstanding, 3'd0);
        check_val("drain3_done", ins_done, 1'b0);
        step(); ins_done_ack = 1'b0;
        check_val("stray_ack_outst", outstanding, 3'd0);
        check_val("stray_ack_done", ins_done, 1'b0);

        // reset while busy with two queued
        ins_data = mk_ins(r0, 4'b0001); ins_valid = 1'b1; step();
        ins_data = mk_ins(r1, 4'b0001); step();
        ins_data = mk_ins(r2, 4'b0001); step();
        ins_valid = 1'b0;
        exp_q.push_back(r0);
        wait_busy("wb_r0");
        check_val("pre_rst_outst", outstanding, 3'd3);
        rst = 1'b1;
        step(); rst = 1'b0;
        check_val("mid_rst_ready", ins_ready, 1'b1);
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_outst", outstanding, 3'd0);
        check_val("mid_rst_done", ins_done, 1'b0);
        check_val("mid_rst_ddr", reg_rd_ddr_addr, 32'h0);
        check_val("mid_rst_bid", reg_rd_bank_id, 8'h0);
        wr_done = 1'b1;
        step(); wr_done = 1'b0;
        step(); step();
        check_val("post_rst_done", ins_done, 1'b0);
        check_val("post_rst_busy", busy, 1'b0);
        check_val("post_rst_outst", outstanding, 3'd0);
        check_val("post_rst_start", start, 1'b0);

        check_val("sb_count", cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check_val($sformatf("sb_cmd%0d", i), cap_q[i], exp_q[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_ins_queue_parser.md
Name: load_ins_queue_parser

Overview:
Next-generation LOAD instruction front end for the scheduler. It accepts 96-bit LOAD instructions into a parametrised command queue, so the scheduler can issue up to CMD_DEPTH instructions ahead. Queued commands are dispatched one at a time to the DDR-read/write engine as start pulses with decoded register fields. Per-instruction completions are counted and returned through a level/ack done handshake. Non-LOAD headers are rejected with an error pulse instead of stalling.

Parameters:
IWB_SEL_W, 2, width of input-weight-buffer select field
BID_W, 8, bank id width
MAX_ADDR_W, 12, bank address width
DDR_ADDR_W, 32, DDR address width
LINE_SIZE_W, 12, line size width
ALL_SIZE_W, 16, total size width
INS_LEN, 96, instruction length
CMD_DEPTH, 4, max outstanding instructions (queued + executing + done-unacked); power of 2, >=2

Ports:
clk  in  1  scheduler clock
rst  in  1  synchronous active-high reset
ins_data  in  INS_LEN  instruction word
ins_valid  in  1  instruction valid
ins_ready  out  1  instruction may be accepted this cycle
ins_err  out  1  one-cycle pulse: accepted instruction had a non-LOAD header
ins_done  out  1  at least one completed instruction not yet acknowledged
ins_done_ack  in  1  consumes one completion while ins_done=1
wr_done  in  1  pulse from write module: current command finished
start  out  1  one-cycle trigger for the engine
busy  out  1  a dispatched command is executing
outstanding  out  $clog2(CMD_DEPTH+1)  queued + executing + unacked-done count
reg_rd_iwb_id  out  IWB_SEL_W  ins_data[63:62]
reg_rd_bank_id  out  BID_W  ins_data[19:12]
reg_rd_bank_addr  out  MAX_ADDR_W  ins_data[11:0]
reg_rd_line_size  out  LINE_SIZE_W  ins_data[61:50]
reg_rd_total_size  out  ALL_SIZE_W  ins_data[49:34]
reg_zero_fill  out  1  ins_data[33]
reg_rd_ddr_addr  out  DDR_ADDR_W  ins_data[95:64]

Behaviour:
- Reset: all outputs 0, except ins_ready=1. Queue emptied, state IDLE, counters 0. Reset mid-operation discards queued, executing and pending-done work; later wr_done pulses are ignored until a new dispatch.
- Accept: a handshake is ins_valid && ins_ready. ins_ready = (outstanding < CMD_DEPTH), combinational from registered counters.
- Header ins_data[31:28]==4'b0001 (HEAD_LOAD): decoded fields are pushed to the queue.
- Any other header: the word is consumed and not queued; ins_err=1 on the next cycle; outstanding is unchanged and no done is produced.
- outstanding = queue_count + busy + done_pending. It increments on a LOAD accept and decrements on done consumption (ins_done && ins_done_ack). Both in the same cycle gives net 0.
- Dispatch FSM:
  - IDLE: if queue is non-empty, pop the head, latch it into the reg_* output registers, go to BUSY. start=1 in the cycle after the pop (registered). busy=1 from that cycle.
  - BUSY: on wr_done, done_pending += 1 and go to IDLE. The next pop happens the cycle after earliest, so one command executes at a time.
  - wr_done in IDLE: ignored.
- Latency: LOAD accepted at cycle T into an empty, idle block → pop at T+1, start and new reg_* visible at T+2.
- reg_* outputs change only at pop and hold their last value otherwise.
- ins_done = (done_pending != 0), registered. Each ack while ins_done=1 decrements done_pending by 1. wr_done and ack in the same cycle leave done_pending unchanged. An ack while ins_done=0 is ignored.
- Overflow is impossible by construction: the outstanding cap bounds queue_count and done_pending by CMD_DEPTH.
- Full boundary: at outstanding==CMD_DEPTH, ins_ready=0, so non-LOAD words are also stalled.

Decomposition:
- Shared package load_ins_pkg:
  - HEAD_LOAD constant
  - field bit-position constants (hi/lo per field)
  - dispatch state encoding (IDLE, BUSY)
  - packed decoded-command struct width
- Sub-module ld_cmd_fifo: synchronous FIFO, width = packed command width, depth CMD_DEPTH. Ports: push/pop/full/empty/count. Same-cycle push+pop is allowed when non-empty.

Test Plan:
- Single LOAD, ddr_addr=0x1000_0040, bank_id=0x05, bank_addr=0x123, line=0x040, total=0x0200, zf=1, iwb=2 accepted at T → start at T+2 with exactly those reg_* values; wr_done at T+10 → ins_done=1 at T+11; ack → ins_done=0, outstanding=0.
- Back-to-back: 4 LOADs on consecutive cycles (CMD_DEPTH=4) → all accepted; ins_ready=0 after the 4th. A 5th valid is held until the first ack. Starts occur in order, one per wr_done, with matching fields.
- Header 4'b0010 instruction → accepted, ins_err pulse 1 cycle, no start, outstanding unchanged, ins_done stays 0.
- Three completions with no ack → done_pending=3, ins_done held high. Three acks → ins_done drops after the third. wr_done coincident with ack leaves the count unchanged.
- wr_done pulsed while IDLE with an empty queue → no done, no state change.
- Reset asserted while BUSY with 2 queued → next cycle ins_ready=1, busy=0, outstanding=0, ins_done=0, reg_* = 0. A subsequent wr_done is ignored.
